// File: rtl/escalonador_bcd_pkg.sv
// escalonador_bcd_pkg: shared FSM encoding and BCD/binary widths for the converter scheduler.
package escalonador_bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ENTREGA  = 2'd2
    } estado_t;

    localparam int LARGURA_BIN = 8;
    localparam int DIGITOS_BCD = 3;
    localparam int LARGURA_BCD = 12;

endpackage

// File: rtl/escalonador_conversor_bcd_arbitro.sv
// arbitro_round_robin: rotating-priority encoder, first asserted request at or above the pointer wins.
module arbitro_round_robin #(
    parameter int N_CANAIS = 4,
    parameter int W        = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic [N_CANAIS-1:0] req_i,
    input  logic [W-1:0]        ponteiro_i,
    output logic [W-1:0]        grant_o,
    output logic                grant_valido_o
);

    logic [W-1:0] idx;

    // Scan from farthest to nearest so the channel closest to the pointer overwrites the rest.
    always_comb begin
        idx            = '0;
        grant_o        = '0;
        grant_valido_o = 1'b0;
        for (int k = N_CANAIS - 1; k >= 0; k--) begin
            idx = W'((int'(ponteiro_i) + k) % N_CANAIS);
            if (req_i[idx]) begin
                grant_o        = idx;
                grant_valido_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/escalonador_conversor_bcd.sv
// escalonador_conversor_bcd: round-robin time-sharing of one external binary-to-BCD converter,
// with per-channel ack, result and held display value.
module escalonador_conversor_bcd
    import escalonador_bcd_pkg::*;
#(
    parameter int N_CANAIS      = 4,
    parameter int LATENCIA_CONV = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [N_CANAIS-1:0]             req,
    input  logic [LARGURA_BIN*N_CANAIS-1:0] valor,
    output logic [LARGURA_BIN-1:0]          conv_binario,
    input  logic [3:0]                      conv_centenas,
    input  logic [3:0]                      conv_dezenas,
    input  logic [3:0]                      conv_unidades,
    output logic [N_CANAIS-1:0]             ack,
    output logic [LARGURA_BCD-1:0]          resultado,
    output logic [2:0]                      canal_resultado,
    output logic [LARGURA_BCD*N_CANAIS-1:0] bcd_canais,
    output logic                            ocupado
);

    localparam int W = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

    estado_t                         estado_q;
    logic [W-1:0]                    ponteiro_q;
    logic [W-1:0]                    canal_q;
    logic [2:0]                      cnt_q;
    logic [LARGURA_BCD-1:0]          digitos_q;
    logic [LARGURA_BIN-1:0]          conv_binario_q;
    logic [N_CANAIS-1:0]             ack_q;
    logic [LARGURA_BCD-1:0]          resultado_q;
    logic [2:0]                      canal_resultado_q;
    logic [LARGURA_BCD*N_CANAIS-1:0] bcd_q;
    logic                            ocupado_q;
    logic [W-1:0]                    grant;
    logic                            grant_valido;

    arbitro_round_robin #(.N_CANAIS(N_CANAIS), .W(W)) u_arbitro (
        .req_i          (req),
        .ponteiro_i     (ponteiro_q),
        .grant_o        (grant),
        .grant_valido_o (grant_valido)
    );

    // ocupado is registered, so it stays high through the cycle the ack is visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q          <= OCIOSO;
            ponteiro_q        <= '0;
            canal_q           <= '0;
            cnt_q             <= '0;
            digitos_q         <= '0;
            conv_binario_q    <= '0;
            ack_q             <= '0;
            resultado_q       <= '0;
            canal_resultado_q <= '0;
            bcd_q             <= '0;
            ocupado_q         <= 1'b0;
        end else begin
            ack_q             <= '0;
            resultado_q       <= '0;
            canal_resultado_q <= '0;
            ocupado_q         <= (estado_q != OCIOSO) || grant_valido;
            case (estado_q)
                OCIOSO: begin
                    if (grant_valido) begin
                        conv_binario_q <= valor[LARGURA_BIN*grant +: LARGURA_BIN];
                        canal_q        <= grant;
                        cnt_q          <= 3'(LATENCIA_CONV);
                        estado_q       <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        digitos_q <= {conv_centenas, conv_dezenas, conv_unidades};
                        estado_q  <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (req[canal_q]) begin
                        ack_q[canal_q]                            <= 1'b1;
                        resultado_q                               <= digitos_q;
                        canal_resultado_q                         <= 3'(canal_q);
                        bcd_q[LARGURA_BCD*canal_q +: LARGURA_BCD] <= digitos_q;
                    end
                    ponteiro_q <= (canal_q == W'(N_CANAIS - 1)) ? '0 : canal_q + 1'b1;
                    estado_q   <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign conv_binario    = conv_binario_q;
    assign ack             = ack_q;
    assign resultado       = resultado_q;
    assign canal_resultado = canal_resultado_q;
    assign bcd_canais      = bcd_q;
    assign ocupado         = ocupado_q;

endmodule

// File: tb/tb_escalonador_conversor_bcd.sv
// tb_escalonador_conversor_bcd: scoreboard bench for the BCD converter scheduler (LATENCIA 1 and 3).
module tb_escalonador_conversor_bcd;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req1 = '0, req3 = '0;
    logic [8*N-1:0] valor1 = '0, valor3 = '0;
    logic [7:0]     cb1, cb3;
    logic [3:0]     cc1, cd1, cu1, cc3, cd3, cu3;
    logic [N-1:0]   ack1, ack3;
    logic [11:0]    res1, res3;
    logic [2:0]     cr1, cr3;
    logic [12*N-1:0] bcd1, bcd3;
    logic           ocu1, ocu3;
    logic           force_x3 = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          ch;
        logic [11:0] res;
    } exp_t;
    exp_t        sb[$];
    logic [11:0] m_bcd[N];

    function automatic logic [11:0] to_bcd(input logic [7:0] b);
        return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
    endfunction

    function automatic logic [12*N-1:0] m_pack();
        logic [12*N-1:0] p;
        for (int i = 0; i < N; i++) p[12*i +: 12] = m_bcd[i];
        return p;
    endfunction

    assign {cc1, cd1, cu1} = to_bcd(cb1);
    assign {cc3, cd3, cu3} = force_x3 ? 12'hxxx : to_bcd(cb3);

    escalonador_conversor_bcd #(.N_CANAIS(N), .LATENCIA_CONV(1)) d1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .valor(valor1), .conv_binario(cb1),
        .conv_centenas(cc1), .conv_dezenas(cd1), .conv_unidades(cu1), .ack(ack1),
        .resultado(res1), .canal_resultado(cr1), .bcd_canais(bcd1), .ocupado(ocu1)
    );

    escalonador_conversor_bcd #(.N_CANAIS(N), .LATENCIA_CONV(3)) d3 (
        .clk(clk), .reset_n(reset_n), .req(req3), .valor(valor3), .conv_binario(cb3),
        .conv_centenas(cc3), .conv_dezenas(cd3), .conv_unidades(cu3), .ack(ack3),
        .resultado(res3), .canal_resultado(cr3), .bcd_canais(bcd3), .ocupado(ocu3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack1(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack1 == '0 && n < lim);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req1 = '0;
        req3 = '0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) m_bcd[i] = '0;
        checks++; if (ack1 !== '0) begin failures++; $display("FAIL reset_ack got=%h exp=0", ack1); end
        checks++; if (res1 !== '0) begin failures++; $display("FAIL reset_resultado got=%h exp=0", res1); end
        checks++; if (cr1 !== '0) begin failures++; $display("FAIL reset_canal got=%0d exp=0", cr1); end
        checks++; if (cb1 !== '0) begin failures++; $display("FAIL reset_conv_binario got=%0d exp=0", cb1); end
        checks++; if (bcd1 !== '0) begin failures++; $display("FAIL reset_bcd_canais got=%h exp=0", bcd1); end
        checks++; if (ocu1 !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", ocu1); end
        checks++; if ({ack3, res3, cr3, cb3, bcd3, ocu3} !== '0) begin failures++; $display("FAIL reset_lat3 got=%h exp=0", {ack3, res3, cr3, cb3, bcd3, ocu3}); end
    endtask

    task automatic test_single();
        int n;
        int ocup;
        sb.push_back('{0, 12'h255});
        valor1[7:0] = 8'd255;
        req1 = 4'b0001;
        tick();
        valor1[7:0] = 8'd1;
        n = 1;
        ocup = int'(ocu1);
        while (ack1 == '0 && n < 10) begin
            tick();
            n++;
            ocup += int'(ocu1);
        end
        checks++; if (n - 1 != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", n - 1); end
        checks++; if (ack1 !== 4'(1 << sb[0].ch)) begin failures++; $display("FAIL single_ack got=%b exp=%b", ack1, 4'(1 << sb[0].ch)); end
        checks++; if (res1 !== sb[0].res) begin failures++; $display("FAIL single_resultado got=%h exp=%h", res1, sb[0].res); end
        checks++; if (cr1 !== 3'(sb[0].ch)) begin failures++; $display("FAIL single_canal got=%0d exp=%0d", cr1, sb[0].ch); end
        m_bcd[sb[0].ch] = sb[0].res;
        void'(sb.pop_front());
        checks++; if (bcd1 !== m_pack()) begin failures++; $display("FAIL single_bcd got=%h exp=%h", bcd1, m_pack()); end
        req1 = '0;
        tick();
        ocup += int'(ocu1);
        checks++; if (ocup != 3) begin failures++; $display("FAIL single_ocupado_cycles got=%0d exp=3", ocup); end
        checks++; if (ack1 !== '0) begin failures++; $display("FAIL single_ack_pulse got=%b exp=0", ack1); end
    endtask

    task automatic test_all_channels();
        int n;
        int last;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) m_bcd[i] = '0;
        valor1 = {8'd7, 8'd100, 8'd99, 8'd0};
        sb.push_back('{0, 12'h000});
        sb.push_back('{1, 12'h099});
        sb.push_back('{2, 12'h100});
        sb.push_back('{3, 12'h007});
        req1 = 4'b1111;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack1(10, n);
            checks++;
            if (ack1 !== 4'(1 << sb[0].ch) || res1 !== sb[0].res || cr1 !== 3'(sb[0].ch)) begin
                failures++;
                $display("FAIL all_ack%0d got ack=%b res=%h ch=%0d exp ack=%b res=%h ch=%0d", k, ack1, res1, cr1, 4'(1 << sb[0].ch), sb[0].res, sb[0].ch);
            end
            if (k > 0) begin
                checks++; if (cyc - last != 3) begin failures++; $display("FAIL all_spacing%0d got=%0d exp=3", k, cyc - last); end
            end
            last = cyc;
            m_bcd[sb[0].ch] = sb[0].res;
            req1[sb[0].ch] = 1'b0;
            void'(sb.pop_front());
        end
        checks++; if (bcd1 !== m_pack()) begin failures++; $display("FAIL all_bcd got=%h exp=%h", bcd1, m_pack()); end
    endtask

    task automatic test_fairness();
        int n;
        valor1[7:0] = 8'd42;
        valor1[15:8] = 8'd200;
        sb.push_back('{1, 12'h200});
        req1 = 4'b0010;
        wait_ack1(10, n);
        checks++; if (ack1 !== 4'b0010 || res1 !== 12'h200) begin failures++; $display("FAIL fair_ch1 got ack=%b res=%h exp ack=0010 res=200", ack1, res1); end
        m_bcd[1] = 12'h200;
        void'(sb.pop_front());
        sb.push_back('{0, 12'h042});
        sb.push_back('{1, 12'h200});
        sb.push_back('{0, 12'h042});
        req1 = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_ack1(10, n);
            checks++;
            if (ack1 !== 4'(1 << sb[0].ch) || res1 !== sb[0].res) begin
                failures++;
                $display("FAIL fair_order%0d got ack=%b res=%h exp ack=%b res=%h", k, ack1, res1, 4'(1 << sb[0].ch), sb[0].res);
            end
            m_bcd[sb[0].ch] = sb[0].res;
            void'(sb.pop_front());
        end
        req1 = '0;
        checks++; if (bcd1 !== m_pack()) begin failures++; $display("FAIL fair_bcd got=%h exp=%h", bcd1, m_pack()); end
    endtask

    task automatic test_withdraw();
        int n;
        int seen;
        valor1[23:16] = 8'd55;
        req1 = 4'b0100;
        tick();
        req1 = '0;
        seen = 0;
        repeat (5) begin
            tick();
            if (ack1 != '0) seen++;
        end
        checks++; if (cb1 !== 8'd55) begin failures++; $display("FAIL withdraw_operand got=%0d exp=55", cb1); end
        checks++; if (seen != 0) begin failures++; $display("FAIL withdraw_no_ack got=%0d exp=0", seen); end
        checks++; if (bcd1 !== m_pack()) begin failures++; $display("FAIL withdraw_bcd got=%h exp=%h", bcd1, m_pack()); end
        valor1[31:24] = 8'd31;
        valor1[7:0] = 8'd250;
        sb.push_back('{3, 12'h031});
        sb.push_back('{0, 12'h250});
        req1 = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            wait_ack1(10, n);
            checks++;
            if (ack1 !== 4'(1 << sb[0].ch) || res1 !== sb[0].res || cr1 !== 3'(sb[0].ch)) begin
                failures++;
                $display("FAIL withdraw_next%0d got ack=%b res=%h ch=%0d exp ack=%b res=%h", k, ack1, res1, cr1, 4'(1 << sb[0].ch), sb[0].res);
            end
            m_bcd[sb[0].ch] = sb[0].res;
            req1[sb[0].ch] = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        valor1[15:8] = 8'd123;
        req1 = 4'b0010;
        tick();
        checks++; if (ocu1 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", ocu1); end
        reset_n = 1'b0;
        req1 = 4'b1000;
        valor1[31:24] = 8'd9;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) m_bcd[i] = '0;
        checks++; if ({ack1, res1, cr1, cb1, ocu1} !== '0) begin failures++; $display("FAIL mid_outputs got=%h exp=0", {ack1, res1, cr1, cb1, ocu1}); end
        checks++; if (bcd1 !== '0) begin failures++; $display("FAIL mid_bcd got=%h exp=0", bcd1); end
        sb.push_back('{3, 12'h009});
        wait_ack1(10, n);
        checks++;
        if (ack1 !== 4'(1 << sb[0].ch) || res1 !== sb[0].res || n != 3) begin
            failures++;
            $display("FAIL mid_fresh got ack=%b res=%h cycles=%0d exp ack=%b res=%h cycles=3", ack1, res1, n, 4'(1 << sb[0].ch), sb[0].res);
        end
        m_bcd[sb[0].ch] = sb[0].res;
        void'(sb.pop_front());
        req1 = '0;
        tick();
        checks++; if (bcd1 !== m_pack()) begin failures++; $display("FAIL mid_bcd_after got=%h exp=%h", bcd1, m_pack()); end
    endtask

    task automatic test_latencia3();
        int n;
        valor3[7:0] = 8'd128;
        force_x3 = 1'b1;
        req3 = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) force_x3 = 1'b0;
        end while (ack3 == '0 && n < 12);
        checks++; if (n - 1 != 4) begin failures++; $display("FAIL lat3_latency got=%0d exp=4", n - 1); end
        checks++; if (ack3 !== 4'b0001 || cr3 !== 3'd0) begin failures++; $display("FAIL lat3_ack got ack=%b ch=%0d exp ack=0001 ch=0", ack3, cr3); end
        checks++; if (res3 !== 12'h128) begin failures++; $display("FAIL lat3_resultado got=%h exp=128", res3); end
        checks++; if (bcd3[11:0] !== 12'h128) begin failures++; $display("FAIL lat3_bcd got=%h exp=128", bcd3[11:0]); end
        req3 = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_fairness();
        test_withdraw();
        test_reset_mid();
        test_latencia3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
